// File: rtl/parking_gate_tracker.sv
// Single-gate parking occupancy tracker: decodes the blocking order of two beam
// sensors into entry/exit/abort events and maintains a saturating car count.
module parking_gate_tracker #(
  parameter int unsigned CAPACITY       = 8,
  parameter int unsigned CNT_W          = 4,
  parameter int unsigned TIMEOUT_CYCLES = 36000000,
  parameter int unsigned TO_W           = 26
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             sens_a,
  input  logic             sens_b,
  output logic [CNT_W-1:0] occupancy,
  output logic             full,
  output logic             empty,
  output logic             entry_pulse,
  output logic             exit_pulse,
  output logic             reject_pulse,
  output logic             error_pulse
);

  typedef enum logic [2:0] {
    IDLE, IN_A, IN_AB, IN_B, OUT_B, OUT_BA, OUT_A, WAIT_CLEAR
  } state_t;

  localparam logic [CNT_W-1:0] CAP_V  = CNT_W'(CAPACITY);
  localparam logic [TO_W-1:0]  TO_MAX = TO_W'(TIMEOUT_CYCLES - 1);

  state_t           state_q, state_d;
  logic [TO_W-1:0]  to_cnt_q, to_cnt_d;
  logic [CNT_W-1:0] occ_d;
  logic [1:0]       sens;
  logic             err, ent_done, ext_done;
  logic             ent_d, ext_d, rej_d;

  assign sens = {sens_a, sens_b};

  always_comb begin
    state_d  = state_q;
    err      = 1'b0;
    ent_done = 1'b0;
    ext_done = 1'b0;
    case (state_q)
      IDLE: begin
        case (sens)
          2'b10:   state_d = IN_A;
          2'b01:   state_d = OUT_B;
          2'b11:   begin state_d = WAIT_CLEAR; err = 1'b1; end
          default: state_d = IDLE;
        endcase
      end
      IN_A: begin
        case (sens)
          2'b11:   state_d = IN_AB;
          2'b00:   state_d = IDLE;
          2'b01:   begin state_d = WAIT_CLEAR; err = 1'b1; end
          default: state_d = IN_A;
        endcase
      end
      IN_AB: begin
        case (sens)
          2'b01:   state_d = IN_B;
          2'b10:   state_d = IN_A;
          2'b00:   begin state_d = WAIT_CLEAR; err = 1'b1; end
          default: state_d = IN_AB;
        endcase
      end
      IN_B: begin
        case (sens)
          2'b00:   begin state_d = IDLE; ent_done = 1'b1; end
          2'b11:   state_d = IN_AB;
          2'b10:   begin state_d = WAIT_CLEAR; err = 1'b1; end
          default: state_d = IN_B;
        endcase
      end
      OUT_B: begin
        case (sens)
          2'b11:   state_d = OUT_BA;
          2'b00:   state_d = IDLE;
          2'b10:   begin state_d = WAIT_CLEAR; err = 1'b1; end
          default: state_d = OUT_B;
        endcase
      end
      OUT_BA: begin
        case (sens)
          2'b10:   state_d = OUT_A;
          2'b01:   state_d = OUT_B;
          2'b00:   begin state_d = WAIT_CLEAR; err = 1'b1; end
          default: state_d = OUT_BA;
        endcase
      end
      OUT_A: begin
        case (sens)
          2'b00:   begin state_d = IDLE; ext_done = 1'b1; end
          2'b11:   state_d = OUT_BA;
          2'b01:   begin state_d = WAIT_CLEAR; err = 1'b1; end
          default: state_d = OUT_A;
        endcase
      end
      default: begin
        if (sens == 2'b00) state_d = IDLE;
      end
    endcase

    // Timeout only fires when the decoder would otherwise hold its state.
    if (state_q != IDLE && state_q != WAIT_CLEAR && state_d == state_q &&
        to_cnt_q == TO_MAX) begin
      state_d = WAIT_CLEAR;
      err     = 1'b1;
    end

    if (state_d != state_q)
      to_cnt_d = '0;
    else if (state_q != IDLE && state_q != WAIT_CLEAR)
      to_cnt_d = to_cnt_q + TO_W'(1);
    else
      to_cnt_d = '0;

    occ_d = occupancy;
    ent_d = 1'b0;
    ext_d = 1'b0;
    rej_d = 1'b0;
    if (ent_done) begin
      if (occupancy < CAP_V) begin
        occ_d = occupancy + CNT_W'(1);
        ent_d = 1'b1;
      end else begin
        rej_d = 1'b1;
      end
    end else if (ext_done) begin
      if (occupancy != '0) begin
        occ_d = occupancy - CNT_W'(1);
        ext_d = 1'b1;
      end else begin
        rej_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      to_cnt_q     <= '0;
      occupancy    <= '0;
      full         <= 1'b0;
      empty        <= 1'b1;
      entry_pulse  <= 1'b0;
      exit_pulse   <= 1'b0;
      reject_pulse <= 1'b0;
      error_pulse  <= 1'b0;
    end else begin
      state_q      <= state_d;
      to_cnt_q     <= to_cnt_d;
      occupancy    <= occ_d;
      full         <= (occ_d == CAP_V);
      empty        <= (occ_d == '0);
      entry_pulse  <= ent_d;
      exit_pulse   <= ext_d;
      reject_pulse <= rej_d;
      error_pulse  <= err;
    end
  end

endmodule

// File: tb/tb_parking_gate_tracker.sv
// Bench for parking_gate_tracker: directed passages plus random sensor traffic,
// compared every cycle against a position-along-path reference model.
module tb_parking_gate_tracker;

  localparam int CAP = 8;
  localparam int TO  = 100;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       sens_a, sens_b;
  logic [3:0] occupancy;
  logic       full, empty, entry_pulse, exit_pulse, reject_pulse, error_pulse;

  parking_gate_tracker #(
    .CAPACITY(CAP), .CNT_W(4), .TIMEOUT_CYCLES(TO), .TO_W(7)
  ) dut (
    .clk(clk), .rst_n(rst_n), .sens_a(sens_a), .sens_b(sens_b),
    .occupancy(occupancy), .full(full), .empty(empty),
    .entry_pulse(entry_pulse), .exit_pulse(exit_pulse),
    .reject_pulse(reject_pulse), .error_pulse(error_pulse)
  );

  always #5 clk = ~clk;

  int vectors = 0;
  int miscompares = 0;

  // Model: direction (+1 entry, -1 exit, 0 idle) and position 0..3 along that path.
  int m_dir, m_pos, m_timer, m_occ;
  bit m_wait, m_ent, m_ext, m_rej, m_err;

  function automatic int posof(input logic [1:0] p, input int dir);
    case (p)
      2'b00:   return 0;
      2'b11:   return 2;
      2'b10:   return (dir > 0) ? 1 : 3;
      default: return (dir > 0) ? 3 : 1;
    endcase
  endfunction

  task automatic m_reset();
    m_dir = 0; m_pos = 0; m_timer = 0; m_occ = 0; m_wait = 0;
    m_ent = 0; m_ext = 0; m_rej = 0; m_err = 0;
  endtask

  task automatic m_go_wait();
    m_wait = 1; m_err = 1; m_dir = 0; m_pos = 0; m_timer = 0;
  endtask

  task automatic m_step(input logic [1:0] p);
    int np;
    m_ent = 0; m_ext = 0; m_rej = 0; m_err = 0;
    if (m_wait) begin
      if (p == 2'b00) m_wait = 0;
    end else if (m_dir == 0) begin
      if (p == 2'b10)      begin m_dir = 1;  m_pos = 1; m_timer = 0; end
      else if (p == 2'b01) begin m_dir = -1; m_pos = 1; m_timer = 0; end
      else if (p == 2'b11) m_go_wait();
    end else begin
      np = posof(p, m_dir);
      if (np == m_pos) begin
        if (m_timer == TO - 1) m_go_wait();
        else m_timer++;
      end else if (np == 0 && m_pos == 3) begin
        if (m_dir > 0) begin
          if (m_occ < CAP) begin m_occ++; m_ent = 1; end else m_rej = 1;
        end else begin
          if (m_occ > 0) begin m_occ--; m_ext = 1; end else m_rej = 1;
        end
        m_dir = 0; m_pos = 0; m_timer = 0;
      end else if (np == 0 && m_pos == 1) begin
        m_dir = 0; m_pos = 0; m_timer = 0;
      end else if (np != 0 && (np - m_pos == 1 || m_pos - np == 1)) begin
        m_pos = np; m_timer = 0;
      end else begin
        m_go_wait();
      end
    end
  endtask

  task automatic check(input string tag);
    logic [9:0] obs, exp;
    obs = {occupancy, full, empty, entry_pulse, exit_pulse, reject_pulse, error_pulse};
    exp = {4'(m_occ), 1'(m_occ == CAP), 1'(m_occ == 0), m_ent, m_ext, m_rej, m_err};
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed occ/full/empty/ent/ext/rej/err=%b expected %b", tag, obs, exp);
    end
  endtask

  task automatic apply(input logic [1:0] p, input int n, input string tag);
    {sens_a, sens_b} = p;
    repeat (n) begin
      @(posedge clk);
      m_step(p);
      #1;
      check(tag);
    end
  endtask

  task automatic entry(input int h, input string tag);
    apply(2'b10, h, tag); apply(2'b11, h, tag); apply(2'b01, h, tag); apply(2'b00, h, tag);
  endtask

  task automatic exit_seq(input int h, input string tag);
    apply(2'b01, h, tag); apply(2'b11, h, tag); apply(2'b10, h, tag); apply(2'b00, h, tag);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    m_reset();
    @(posedge clk);
    #1;
    check("reset");
    rst_n = 1'b1;
  endtask

  initial begin
    sens_a = 1'b0;
    sens_b = 1'b0;
    do_reset();

    apply(2'b00, 5, "idle");
    entry(5, "clean_entry");
    entry(3, "entry2");
    entry(2, "entry3");
    exit_seq(3, "clean_exit");
    exit_seq(2, "exit_to_1");
    exit_seq(2, "exit_to_0");
    exit_seq(2, "exit_empty_reject");

    for (int i = 0; i < CAP; i++) entry(1, "fill");
    entry(2, "entry_full_reject");

    apply(2'b10, 2, "abort1"); apply(2'b00, 2, "abort1");
    apply(2'b10, 2, "abort2"); apply(2'b11, 2, "abort2");
    apply(2'b10, 2, "abort2"); apply(2'b00, 2, "abort2");
    apply(2'b10, 2, "abort3"); apply(2'b11, 2, "abort3"); apply(2'b01, 2, "abort3");
    apply(2'b11, 2, "abort3"); apply(2'b10, 2, "abort3"); apply(2'b00, 2, "abort3");

    apply(2'b11, 3, "idle_11_error"); apply(2'b00, 2, "wait_clear");
    apply(2'b10, 1, "illegal_a_b");   apply(2'b01, 2, "illegal_a_b"); apply(2'b00, 2, "illegal_a_b");

    apply(2'b10, TO + 3, "timeout_hold");
    apply(2'b11, 3, "wait_no_count"); apply(2'b01, 3, "wait_no_count");
    apply(2'b00, 3, "wait_no_count");
    apply(2'b01, TO - 1, "exit_near_timeout"); apply(2'b11, 2, "exit_near_timeout");
    apply(2'b10, 2, "exit_near_timeout"); apply(2'b00, 2, "exit_near_timeout");

    for (int i = 0; i < 600; i++) begin
      int unsigned r;
      r = $urandom_range(0, 9);
      if (r < 3)      entry($urandom_range(1, 3), "rand_entry");
      else if (r < 6) exit_seq($urandom_range(1, 3), "rand_exit");
      else            apply(2'($urandom_range(0, 3)), $urandom_range(1, 4), "rand_pattern");
    end

    do_reset();
    for (int i = 0; i < 5; i++) entry(1, "refill");
    apply(2'b10, 2, "mid_passage"); apply(2'b11, 2, "mid_passage");
    #2;
    rst_n = 1'b0;
    m_reset();
    #1;
    check("async_reset");
    {sens_a, sens_b} = 2'b11;
    @(posedge clk);
    #1;
    check("held_reset");
    rst_n = 1'b1;
    apply(2'b11, 2, "blocked_after_reset");
    apply(2'b00, 2, "blocked_after_reset");
    entry(2, "post_reset_entry");

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
